// File: rtl/brq_pkg.sv
// Shared types and helpers for the IFU instruction aligner.
//   aligner_res_t  : residue upper halfword held between fetch words
//   is_compressed  : 1 when a halfword starts a 16-bit (RVC) instruction
package brq_pkg;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [15:0] half;
    } aligner_res_t;

    localparam logic [31:0] PC_STEP_C = 32'd2;
    localparam logic [31:0] PC_STEP_W = 32'd4;

    function automatic logic is_compressed(input logic [15:0] half);
        return half[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/brq_ifu_instr_aligner.sv
// IFU instruction aligner: turns a stream of word-aligned 32-bit fetch words
// into one instruction per output handshake (16-bit compressed or 32-bit,
// including 32-bit instructions straddling two fetch words), tracks the PC
// and restarts at halfword-aligned redirect targets.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   redirect_i/_addr_i      flush and restart at redirect_addr_i (bit 0 ignored)
//   in_valid_i/in_ready_o   fetch word handshake
//   in_rdata_i, in_err_i    fetch word and its bus error flag
//   out_valid_o/out_ready_i instruction handshake
//   out_rdata_o             instruction ({16'h0, half} when compressed)
//   out_addr_o              PC of the instruction
//   out_is_compr_o          instruction is 16-bit
//   out_err_o               fetch error attached to the instruction
//   out_err_plus2_o         error only on the upper half of a straddler
module brq_ifu_instr_aligner
    import brq_pkg::*;
#(
    parameter bit          RV32C   = 1'b1,
    parameter logic [31:0] ResetPc = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_addr_o,
    output logic        out_is_compr_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o
);

    logic [31:0]  pc_q, pc_d;
    aligner_res_t res_q, res_d;
    logic         skip_lo_q, skip_lo_d;
    // Without RVC a halfword-aligned redirect target cannot be fetched
    // correctly; the next emitted instruction is flagged as an error.
    logic         misalign_q, misalign_d;

    logic [15:0]  in_lo, in_hi;
    logic         in_fire;
    logic         unused_addr_bit0;

    assign in_lo            = in_rdata_i[15:0];
    assign in_hi            = in_rdata_i[31:16];
    assign in_fire          = in_valid_i & out_ready_i;
    assign unused_addr_bit0 = redirect_addr_i[0];
    assign out_addr_o       = pc_q;
    assign out_is_compr_o   = RV32C && is_compressed(out_rdata_o[15:0]);

    always_comb begin
        out_valid_o     = 1'b0;
        in_ready_o      = 1'b0;
        out_rdata_o     = in_rdata_i;
        out_err_o       = 1'b0;
        out_err_plus2_o = 1'b0;
        pc_d            = pc_q;
        res_d           = res_q;
        skip_lo_d       = skip_lo_q;
        misalign_d      = misalign_q;

        if (rst_i) begin
            // handshakes held off while reset is asserted
        end else if (redirect_i) begin
            in_ready_o = 1'b1;
            pc_d       = {redirect_addr_i[31:1], 1'b0};
            res_d      = '0;
            skip_lo_d  = RV32C ? redirect_addr_i[1] : 1'b0;
            misalign_d = RV32C ? 1'b0 : redirect_addr_i[1];
        end else if (!RV32C) begin
            out_valid_o = in_valid_i;
            in_ready_o  = out_ready_i;
            out_err_o   = in_err_i | misalign_q;
            if (in_fire) begin
                pc_d       = pc_q + PC_STEP_W;
                misalign_d = 1'b0;
            end
        end else if (res_q.valid && is_compressed(res_q.half)) begin
            // Compressed residue: emitted without touching the input.
            out_valid_o = 1'b1;
            out_rdata_o = {16'h0000, res_q.half};
            out_err_o   = res_q.err;
            if (out_ready_i) begin
                res_d.valid = 1'b0;
                pc_d        = pc_q + PC_STEP_C;
            end
        end else if (res_q.valid) begin
            // Straddling 32-bit instruction: residue is the lower half.
            out_valid_o     = in_valid_i;
            in_ready_o      = out_ready_i;
            out_rdata_o     = {in_lo, res_q.half};
            out_err_o       = res_q.err | in_err_i;
            out_err_plus2_o = in_err_i & ~res_q.err;
            if (in_fire) begin
                res_d.valid = 1'b1;
                res_d.err   = in_err_i;
                res_d.half  = in_hi;
                pc_d        = pc_q + PC_STEP_W;
            end
        end else if (skip_lo_q) begin
            if (is_compressed(in_hi)) begin
                out_valid_o = in_valid_i;
                in_ready_o  = out_ready_i;
                out_rdata_o = {16'h0000, in_hi};
                out_err_o   = in_err_i;
                if (in_fire) begin
                    skip_lo_d = 1'b0;
                    pc_d      = pc_q + PC_STEP_C;
                end
            end else begin
                // Upper half starts a 32-bit instruction: absorb the word
                // into the residue and wait for the next one.
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    res_d.valid = 1'b1;
                    res_d.err   = in_err_i;
                    res_d.half  = in_hi;
                    skip_lo_d   = 1'b0;
                end
            end
        end else if (is_compressed(in_lo)) begin
            out_valid_o = in_valid_i;
            in_ready_o  = out_ready_i;
            out_rdata_o = {16'h0000, in_lo};
            out_err_o   = in_err_i;
            if (in_fire) begin
                res_d.valid = 1'b1;
                res_d.err   = in_err_i;
                res_d.half  = in_hi;
                pc_d        = pc_q + PC_STEP_C;
            end
        end else begin
            out_valid_o = in_valid_i;
            in_ready_o  = out_ready_i;
            out_err_o   = in_err_i;
            if (in_fire) begin
                pc_d = pc_q + PC_STEP_W;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= ResetPc;
            res_q      <= '0;
            skip_lo_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            res_q      <= res_d;
            skip_lo_q  <= skip_lo_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_brq_ifu_instr_aligner.sv
// Scoreboard bench for brq_ifu_instr_aligner (RV32C=1, ResetPc=0).
// The driver feeds fetch words into a halfword-stream reference model that
// carves instructions out of the stream by their low bits and queues the
// expected results; the monitor pops and compares on every output handshake.
module tb_brq_ifu_instr_aligner;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_rdata_i;
    logic        in_err_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_rdata_o;
    logic [31:0] out_addr_o;
    logic        out_is_compr_o;
    logic        out_err_o;
    logic        out_err_plus2_o;

    brq_ifu_instr_aligner #(.RV32C(1'b1), .ResetPc(32'h0000_0000)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .redirect_i     (redirect_i),
        .redirect_addr_i(redirect_addr_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_rdata_i     (in_rdata_i),
        .in_err_i       (in_err_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_rdata_o    (out_rdata_o),
        .out_addr_o     (out_addr_o),
        .out_is_compr_o (out_is_compr_o),
        .out_err_o      (out_err_o),
        .out_err_plus2_o(out_err_plus2_o)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        compr;
        logic        err;
        logic        p2;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] hq[$];
    logic        he[$];
    logic [31:0] mpc;
    logic        mskip;

    int n_checks = 0;
    int n_pass   = 0;
    int ready_pct  = 100;
    int stall_left = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic model_flush(input logic [31:0] tgt);
        exp_q.delete();
        hq.delete();
        he.delete();
        mpc   = {tgt[31:1], 1'b0};
        mskip = tgt[1];
    endtask

    // Append the word's halfwords to the stream, then carve out every
    // complete instruction at the head of the stream.
    task automatic model_consume(input logic [31:0] w, input logic e);
        exp_t x;
        if (!mskip) begin
            hq.push_back(w[15:0]);
            he.push_back(e);
        end
        hq.push_back(w[31:16]);
        he.push_back(e);
        mskip = 1'b0;
        while (hq.size() > 0) begin
            if (hq[0][1:0] != 2'b11) begin
                x.rdata = {16'h0000, hq[0]};
                x.addr  = mpc;
                x.compr = 1'b1;
                x.err   = he[0];
                x.p2    = 1'b0;
                exp_q.push_back(x);
                void'(hq.pop_front());
                void'(he.pop_front());
                mpc = mpc + 32'd2;
            end else if (hq.size() >= 2) begin
                x.rdata = {hq[1], hq[0]};
                x.addr  = mpc;
                x.compr = 1'b0;
                x.err   = he[0] | he[1];
                x.p2    = he[1] & ~he[0];
                exp_q.push_back(x);
                void'(hq.pop_front());
                void'(hq.pop_front());
                void'(he.pop_front());
                void'(he.pop_front());
                mpc = mpc + 32'd4;
            end else begin
                break;
            end
        end
    endtask

    task automatic cycle_drive(input logic redir, input logic [31:0] raddr, input logic v,
                               input logic [31:0] w, input logic e, output logic consumed);
        @(negedge clk);
        redirect_i      = redir;
        redirect_addr_i = raddr;
        in_valid_i      = v;
        in_rdata_i      = w;
        in_err_i        = e;
        if (stall_left > 0) begin
            out_ready_i = 1'b0;
            stall_left--;
        end else begin
            out_ready_i = ($urandom_range(99) < ready_pct);
        end
        #2;
        consumed = 1'b0;
        if (redir) begin
            model_flush(raddr);
            consumed = v;
        end else if (v && in_ready_o) begin
            model_consume(w, e);
            consumed = 1'b1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic e);
        logic c;
        int   n;
        c = 1'b0;
        n = 0;
        while (!c && n < 300) begin
            cycle_drive(1'b0, 32'h0, 1'b1, w, e, c);
            n++;
        end
        if (!c) chk("word_accept_timeout", {31'h0, c}, 1);
    endtask

    task automatic idle(input int n);
        logic c;
        for (int i = 0; i < n; i++) cycle_drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, c);
    endtask

    task automatic do_redirect(input logic [31:0] addr, input logic v);
        logic c;
        cycle_drive(1'b1, addr, v, $urandom, 1'b0, c);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            idle(1);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [15:0] rand_half();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(1) == 1) h[1:0] = 2'b11;
        else h[1:0] = 2'($urandom_range(2));
        return h;
    endfunction

    // Monitor: compares every instruction handshake and output invariants.
    initial begin
        exp_t        e;
        logic        stall_prev;
        logic [31:0] prd, pad;
        stall_prev = 1'b0;
        prd = 32'h0;
        pad = 32'h0;
        forever begin
            @(negedge clk);
            #4;
            if (rst_i !== 1'b0) begin
                stall_prev = 1'b0;
            end else if (redirect_i) begin
                chk("redirect_outputs", {out_valid_o, in_ready_o}, 2'b01);
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    chk("hold_stable", {out_valid_o, out_rdata_o, out_addr_o}, {1'b1, prd, pad});
                if (out_valid_o && !out_ready_i)
                    chk("stall_in_ready", in_ready_o, 0);
                if (out_valid_o && out_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_instr", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("instr", {out_rdata_o, out_addr_o, out_is_compr_o, out_err_o,
                                      out_err_plus2_o}, e);
                    end
                end
                stall_prev = out_valid_o && !out_ready_i;
                prd = out_rdata_o;
                pad = out_addr_o;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        logic [31:0] a;
        rst_i           = 1'b1;
        redirect_i      = 1'b0;
        redirect_addr_i = 32'h0;
        in_valid_i      = 1'b1;
        in_rdata_i      = 32'h0001_4501;
        in_err_i        = 1'b0;
        out_ready_i     = 1'b1;
        model_flush(32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_valid", out_valid_o, 0);
        chk("reset_in_ready", in_ready_o, 0);
        chk("reset_pc", out_addr_o, 32'h0);
        @(negedge clk);
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        #1;
        chk("post_reset_idle", out_valid_o, 0);

        // two compressed halves in one word
        send_word(32'h0001_4501, 1'b0);
        idle(2);
        chk("pc_after_two_c", out_addr_o, 32'h4);
        // compressed, then straddling 32-bit, then residue
        send_word(32'h0613_4505, 1'b0);
        send_word(32'h1234_0050, 1'b0);
        idle(2);
        // redirect to a halfword target: lower half dropped
        do_redirect(32'h0000_0102, 1'b0);
        send_word(32'h4501_ABCD, 1'b0);
        idle(2);
        chk("addr_after_redirect", out_addr_o, 32'h104);
        // straddler whose upper half carries a bus error
        send_word(32'h0613_4505, 1'b0);
        send_word(32'h1235_0050, 1'b1);
        idle(2);
        // backpressure during a straddling instruction
        send_word(32'h0713_4509, 1'b0);
        stall_left = 3;
        send_word(32'hABCD_0093, 1'b0);
        drain();
        // redirect coincident with a valid input and pending residue
        send_word(32'h0613_4505, 1'b0);
        do_redirect(32'h0000_0200, 1'b1);
        idle(1);
        chk("addr_after_redirect_drop", out_addr_o, 32'h200);
        chk("no_output_after_flush", out_valid_o, 0);
        send_word(32'h0000_4501, 1'b0);
        drain();

        // randomized phase with PC wrap-around targets
        ready_pct = 70;
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(99);
            if (r < 5) begin
                a = $urandom;
                if ($urandom_range(3) == 0) a = 32'hFFFF_FFF0 | {28'h0, a[3:0]};
                do_redirect(a, 1'($urandom_range(1)));
            end else if (r < 15) begin
                idle(1);
            end else begin
                if ($urandom_range(9) == 0) stall_left = $urandom_range(3);
                send_word({rand_half(), rand_half()}, ($urandom_range(9) == 0));
            end
        end
        ready_pct = 100;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
